// File: rtl/tuss_pkg.sv
// Shared definitions for the TUSS configuration sequencer: register map,
// table entry layout, FSM state type and SPI frame builder.
package tuss_pkg;

    localparam int IDX_W   = 4;
    localparam int FRM_PAR = 8;

    localparam logic [5:0] REG_10          = 6'h10;
    localparam logic [5:0] REG_11          = 6'h11;
    localparam logic [5:0] REG_12          = 6'h12;
    localparam logic [5:0] REG_13          = 6'h13;
    localparam logic [5:0] REG_14          = 6'h14;
    localparam logic [5:0] REG_16          = 6'h16;
    localparam logic [5:0] REG_17          = 6'h17;
    localparam logic [5:0] REG_18          = 6'h18;
    localparam logic [5:0] REG_BURST_PULSE = 6'h1A;
    localparam logic [5:0] REG_1B          = 6'h1B;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
        logic       verify;
    } cfg_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_WR_REQ, ST_WR_WAIT, ST_RD_REQ, ST_RD_WAIT,
        ST_CHECK, ST_FAIL, ST_NEXT, ST_DONE, ST_ERR
    } state_t;

    // {rw, addr, parity, data}; parity bit makes the whole frame odd-weight.
    function automatic logic [15:0] frame(input logic rw, input logic [5:0] addr,
                                          input logic [7:0] data);
        logic [15:0] f;
        f          = {rw, addr, 1'b0, data};
        f[FRM_PAR] = ~(^f);
        return f;
    endfunction

endpackage

// File: rtl/tuss_cfg_rom.sv
// Fixed configuration table: entry index -> {addr, data, verify}.
module tuss_cfg_rom
    import tuss_pkg::*;
#(
    parameter int PULSE_NUM = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output cfg_entry_t       entry_o
);

    always_comb begin
        entry_o = '0;
        case (idx_i)
            4'd0:    entry_o = '{REG_10,          8'h25, 1'b1};
            4'd1:    entry_o = '{REG_11,          8'h00, 1'b1};
            4'd2:    entry_o = '{REG_12,          8'hC0, 1'b1};
            4'd3:    entry_o = '{REG_13,          8'h01, 1'b1};
            4'd4:    entry_o = '{REG_14,          8'h03, 1'b1};
            4'd5:    entry_o = '{REG_16,          8'h06, 1'b1};
            4'd6:    entry_o = '{REG_17,          8'h1B, 1'b1};
            4'd7:    entry_o = '{REG_18,          8'hD4, 1'b1};
            4'd8:    entry_o = '{REG_BURST_PULSE, {3'b000, 5'(PULSE_NUM)}, 1'b1};
            4'd9:    entry_o = '{REG_1B,          8'h00, 1'b0};
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/tuss_cfg_seq.sv
// TUSS front-end configuration sequencer: writes the register table over SPI,
// reads back verifiable entries, retries failures and reports done/error.
//  state    | meaning
//  IDLE     | wait for start          LOAD    | select table entry
//  WR_REQ   | issue write frame       WR_WAIT | wait write spi_done / timeout
//  RD_REQ   | issue read frame        RD_WAIT | wait read spi_done / timeout
//  CHECK    | compare read-back       FAIL    | retry or give up
//  NEXT     | advance or finish       DONE/ERR| publish result, back to IDLE
module tuss_cfg_seq
    import tuss_pkg::*;
#(
    parameter int NUM_REGS  = 10,
    parameter int PULSE_NUM = 4,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 2
) (
    input  logic        gclk,
    input  logic        rst,
    input  logic        start,
    output logic        spi_start,
    output logic [15:0] spi_wdata,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [15:0] spi_rdata,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [5:0]  err_addr
);

    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [RETRY_W-1:0] retry_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         rdata_q;
    logic               spi_start_q;
    logic [15:0]        spi_wdata_q;
    logic               busy_q;
    logic               cfg_done_q;
    logic               cfg_err_q;
    logic [5:0]         err_addr_q;

    cfg_entry_t  entry;
    logic [15:0] wr_frame_d;
    logic [15:0] rd_frame_d;
    logic        unused_rdata;

    tuss_cfg_rom #(.PULSE_NUM(PULSE_NUM)) u_rom (
        .idx_i   (idx_q),
        .entry_o (entry)
    );

    assign wr_frame_d   = frame(1'b0, entry.addr, entry.data);
    assign rd_frame_d   = frame(1'b1, entry.addr, 8'h00);
    assign unused_rdata = ^spi_rdata[15:8];

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            rdata_q     <= '0;
            spi_start_q <= 1'b0;
            spi_wdata_q <= '0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            spi_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    idx_q      <= '0;
                    retry_q    <= '0;
                    cfg_done_q <= 1'b0;
                    cfg_err_q  <= 1'b0;
                    err_addr_q <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: state_q <= ST_WR_REQ;
                ST_WR_REQ: if (!spi_busy) begin
                    spi_start_q <= 1'b1;
                    spi_wdata_q <= wr_frame_d;
                    tmo_q       <= TMO_W'(TIMEOUT);
                    state_q     <= ST_WR_WAIT;
                end
                // spi_done is tested first so it wins over a simultaneous timeout.
                ST_WR_WAIT: begin
                    if (spi_done)        state_q <= entry.verify ? ST_RD_REQ : ST_NEXT;
                    else if (tmo_q == '0) state_q <= ST_FAIL;
                    else                 tmo_q   <= tmo_q - 1'b1;
                end
                ST_RD_REQ: if (!spi_busy) begin
                    spi_start_q <= 1'b1;
                    spi_wdata_q <= rd_frame_d;
                    tmo_q       <= TMO_W'(TIMEOUT);
                    state_q     <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (spi_done) begin
                        rdata_q <= spi_rdata[7:0];
                        state_q <= ST_CHECK;
                    end else if (tmo_q == '0) begin
                        state_q <= ST_FAIL;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_CHECK: state_q <= (rdata_q == entry.data) ? ST_NEXT : ST_FAIL;
                ST_FAIL: begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= ST_WR_REQ;
                    end else begin
                        err_addr_q <= entry.addr;
                        state_q    <= ST_ERR;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        retry_q <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    cfg_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                ST_ERR: begin
                    cfg_err_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign spi_start = spi_start_q;
    assign spi_wdata = spi_wdata_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign err_addr  = err_addr_q;

endmodule
